// File: rtl/lc3b_types.sv
// Shared types for the LC-3b line buffer: line/tag typedefs, FSM states and
// the address split between line tag and byte offset.
package lc3b_types;

    localparam int LINE_OFFSET_BITS = 4;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_tag;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WB   = 2'd2,
        FILL = 2'd3
    } lb_state_t;

    function automatic lc3b_word line_base(input lc3b_line_tag tag);
        return {tag, {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/line_buffer_port_if.sv
// CPU-side and pmem-side signal bundle of the line buffer. The buffer is the
// slave of the core's memory port and drives the pmem request lines.
interface line_buffer_port_if;
    import lc3b_types::*;

    logic       mem_read;
    logic       mem_write;
    lc3b_word   mem_address;
    logic [1:0] mem_byte_enable;
    lc3b_word   mem_wdata;
    lc3b_word   mem_rdata;
    logic       mem_resp;

    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_address;
    lc3b_line   pmem_wdata;
    lc3b_line   pmem_rdata;
    logic       pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/line_word_extract.sv
// Combinational word select: picks 16-bit word word_sel_i out of a 128-bit line.
module line_word_extract
    import lc3b_types::*;
(
    input  lc3b_line   line_i,
    input  logic [2:0] word_sel_i,
    output lc3b_word   word_o
);

    logic [6:0] bitOff;

    always_comb begin
        bitOff = {word_sel_i, 4'b0000};
        word_o = line_i[bitOff +: 16];
    end

endmodule

// File: rtl/line_buffer_port.sv
// Single-entry write-back 16-byte line buffer between the LC-3b memory port and
// 128-bit pmem. Define LINE_BUF_PERF_EN to add saturating hit/miss counters.
module line_buffer_port
    import lc3b_types::*;
(
    input  logic                clk,
    input  logic                reset,
    line_buffer_port_if.slave   bus
`ifdef LINE_BUF_PERF_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    lb_state_t    state_q;
    lc3b_line_tag tag_q;
    logic         valid_q;
    logic         dirty_q;
    lc3b_line     data_q;

    lc3b_word     memRdata_q;
    logic         memResp_q;
    logic         pmemRead_q;
    logic         pmemWrite_q;
    lc3b_word     pmemAddress_q;
    lc3b_line     pmemWdata_q;

    lc3b_line_tag reqTag;
    logic         reqActive;
    logic         hit;
    lc3b_word     readWord;
    lc3b_line     mergedLine_d;
    logic [6:0]   bitOff;

    assign reqTag    = bus.mem_address[15:LINE_OFFSET_BITS];
    assign reqActive = bus.mem_read | bus.mem_write;
    assign hit       = valid_q && (tag_q == reqTag);

    line_word_extract uWordExtract (
        .line_i     (data_q),
        .word_sel_i (bus.mem_address[3:1]),
        .word_o     (readWord)
    );

    // Odd addresses only ever touch the high byte of the word, whatever be says.
    always_comb begin
        mergedLine_d = data_q;
        bitOff       = {bus.mem_address[3:1], 4'b0000};
        if (bus.mem_address[0]) begin
            mergedLine_d[bitOff + 7'd8 +: 8] = bus.mem_wdata[15:8];
        end else begin
            if (bus.mem_byte_enable[0]) mergedLine_d[bitOff +: 8] = bus.mem_wdata[7:0];
            if (bus.mem_byte_enable[1]) mergedLine_d[bitOff + 7'd8 +: 8] = bus.mem_wdata[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            valid_q       <= 1'b0;
            dirty_q       <= 1'b0;
            data_q        <= '0;
            memRdata_q    <= '0;
            memResp_q     <= 1'b0;
            pmemRead_q    <= 1'b0;
            pmemWrite_q   <= 1'b0;
            pmemAddress_q <= '0;
            pmemWdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqActive) begin
                        if (hit) begin
                            if (bus.mem_write) begin
                                data_q  <= mergedLine_d;
                                dirty_q <= 1'b1;
                            end else begin
                                memRdata_q <= readWord;
                            end
                            memResp_q <= 1'b1;
                            state_q   <= RESP;
                        end else if (valid_q && dirty_q) begin
                            pmemWrite_q   <= 1'b1;
                            pmemAddress_q <= line_base(tag_q);
                            pmemWdata_q   <= data_q;
                            state_q       <= WB;
                        end else begin
                            pmemRead_q    <= 1'b1;
                            pmemAddress_q <= line_base(reqTag);
                            state_q       <= FILL;
                        end
                    end
                end
                RESP: begin
                    memResp_q <= 1'b0;
                    state_q   <= IDLE;
                end
                WB: begin
                    if (bus.pmem_resp) begin
                        dirty_q       <= 1'b0;
                        pmemWrite_q   <= 1'b0;
                        pmemRead_q    <= 1'b1;
                        pmemAddress_q <= line_base(reqTag);
                        state_q       <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        data_q     <= bus.pmem_rdata;
                        tag_q      <= reqTag;
                        valid_q    <= 1'b1;
                        dirty_q    <= 1'b0;
                        pmemRead_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_rdata    = memRdata_q;
    assign bus.mem_resp     = memResp_q;
    assign bus.pmem_read    = pmemRead_q;
    assign bus.pmem_write   = pmemWrite_q;
    assign bus.pmem_address = pmemAddress_q;
    assign bus.pmem_wdata   = pmemWdata_q;

`ifdef LINE_BUF_PERF_EN
    logic [15:0] hitCount_q;
    logic [15:0] missCount_q;
    logic        startHit;
    logic        startMiss;

    assign startHit  = (state_q == IDLE) && reqActive && hit;
    assign startMiss = (state_q == IDLE) && reqActive && !hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            if (startHit && (hitCount_q != 16'hFFFF)) hitCount_q <= hitCount_q + 16'd1;
            if (startMiss && (missCount_q != 16'hFFFF)) missCount_q <= missCount_q + 16'd1;
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_line_buffer_port.sv
// Directed, table-driven bench for line_buffer_port with a behavioural pmem
// that answers each strobe after a fixed number of cycles.
module tb_line_buffer_port;
    import lc3b_types::*;

    localparam int PMEM_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    line_buffer_port_if bus ();

`ifdef LINE_BUF_PERF_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    line_buffer_port dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LINE_BUF_PERF_EN
        ,
        .hit_count  (hitCount),
        .miss_count (missCount)
`endif
    );

    int passCount = 0;
    int checkCount = 0;

    // Backing store for the two lines the test touches.
    lc3b_line memA;
    lc3b_line memB;

    logic     resGot;
    int       resLat;
    lc3b_word resRdata;
    int       resWb;
    lc3b_word resWbAddr;
    lc3b_line resWbData;
    int       resFill;
    lc3b_word resFillAddr;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [15:0] addr;
        logic [1:0] be;
        logic [15:0] wdata;
        logic       chkRdata;
        logic [15:0] expRdata;
        int         expLat;
        int         expWb;
        logic [15:0] expWbAddr;
        logic [127:0] expWbData;
        int         expFill;
        logic [15:0] expFillAddr;
    } vec_t;

    vec_t vecs [14];

    function automatic lc3b_line lineFor(input lc3b_word addr);
        if (addr == 16'h1230) return memA;
        if (addr == 16'h4560) return memB;
        return '0;
    endfunction

    task automatic storeLine(input lc3b_word addr, input lc3b_line line);
        if (addr == 16'h1230) memA = line;
        else if (addr == 16'h4560) memB = line;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Latency is the number of cycles the request is held, including the mem_resp cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [1:0] be, input logic [15:0] wd);
        int cyc;
        int pWait;
        logic done;
        cyc = 0; pWait = 0; done = 1'b0;
        resGot = 1'b0; resLat = 0; resRdata = '0;
        resWb = 0; resWbAddr = '0; resWbData = '0;
        resFill = 0; resFillAddr = '0;
        @(negedge clk);
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_address = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata = wd;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.pmem_resp = 1'b0;
            if (bus.mem_resp) begin
                done = 1'b1;
                resGot = 1'b1;
                resLat = cyc + 1;
                resRdata = bus.mem_rdata;
            end else if (bus.pmem_write) begin
                if (pWait == 0) begin
                    resWb++;
                    resWbAddr = bus.pmem_address;
                    resWbData = bus.pmem_wdata;
                end
                pWait++;
                if (pWait == PMEM_LAT) begin
                    storeLine(bus.pmem_address, bus.pmem_wdata);
                    bus.pmem_resp = 1'b1;
                    pWait = 0;
                end
            end else if (bus.pmem_read) begin
                if (pWait == 0) begin
                    resFill++;
                    resFillAddr = bus.pmem_address;
                end
                pWait++;
                if (pWait == PMEM_LAT) begin
                    bus.pmem_rdata = lineFor(bus.pmem_address);
                    bus.pmem_resp = 1'b1;
                    pWait = 0;
                end
            end
        end
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    localparam lc3b_line L1 = {16'hEEDD, 16'hCCBB, 16'hAA99, 16'h8877,
                               16'hBEEF, 16'h4433, 16'h2211, 16'h10C3};
    localparam lc3b_line L2 = {16'hA007, 16'hA006, 16'hA005, 16'hA004,
                               16'hA003, 16'hA002, 16'hA001, 16'hA000};
    localparam lc3b_line L1_MERGED  = {16'hEEDD, 16'hCCBB, 16'hAA99, 16'h8877,
                                       16'hBEEF, 16'h5533, 16'h2211, 16'hABC3};
    localparam lc3b_line L1_MERGED2 = {16'hEEDD, 16'hCCBB, 16'hAA99, 16'h8877,
                                       16'hBEEF, 16'h5533, 16'h1234, 16'hABC3};

    initial begin
        int n;
        memA = L1;
        memB = L2;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_address = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp = 1'b0;

        //               rd    wr    addr      be     wdata     chk   rdata    lat wb wbAddr    wbData      fill fillAddr
        vecs[0]  = '{1'b1, 1'b0, 16'h1236, 2'b00, 16'h0000, 1'b1, 16'hBEEF, 5, 0, 16'h0000, '0,         1, 16'h1230};
        vecs[1]  = '{1'b1, 1'b0, 16'h123E, 2'b00, 16'h0000, 1'b1, 16'hEEDD, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h1231, 2'b01, 16'hAB00, 1'b0, 16'h0000, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 16'h1234, 2'b10, 16'h5500, 1'b0, 16'h0000, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000, 1'b1, 16'hABC3, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 1'b1, 16'h5533, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 16'h1236, 2'b00, 16'hFFFF, 1'b0, 16'h0000, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 16'h1236, 2'b00, 16'h0000, 1'b1, 16'hBEEF, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 16'h4560, 2'b00, 16'h0000, 1'b1, 16'hA000, 7, 1, 16'h1230, L1_MERGED,  1, 16'h4560};
        vecs[9]  = '{1'b1, 1'b0, 16'h4562, 2'b00, 16'h0000, 1'b1, 16'hA001, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 16'h1232, 2'b11, 16'h1234, 1'b0, 16'h0000, 5, 0, 16'h0000, '0,         1, 16'h1230};
        vecs[11] = '{1'b1, 1'b0, 16'h1232, 2'b00, 16'h0000, 1'b1, 16'h1234, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000, 1'b1, 16'hABC3, 2, 0, 16'h0000, '0,         0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'h4566, 2'b00, 16'h0000, 1'b1, 16'hA003, 7, 1, 16'h1230, L1_MERGED2, 1, 16'h4560};

        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mem_resp",     {127'b0, bus.mem_resp},   '0);
        checkOutput("rst_mem_rdata",    {112'b0, bus.mem_rdata},  '0);
        checkOutput("rst_pmem_read",    {127'b0, bus.pmem_read},  '0);
        checkOutput("rst_pmem_write",   {127'b0, bus.pmem_write}, '0);
        checkOutput("rst_pmem_address", {112'b0, bus.pmem_address}, '0);
        checkOutput("rst_pmem_wdata",   bus.pmem_wdata, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            checkOutput($sformatf("v%0d_resp", i), {127'b0, resGot}, 128'd1);
            checkOutput($sformatf("v%0d_lat", i), 128'(resLat), 128'(vecs[i].expLat));
            if (vecs[i].chkRdata)
                checkOutput($sformatf("v%0d_rdata", i), {112'b0, resRdata}, {112'b0, vecs[i].expRdata});
            checkOutput($sformatf("v%0d_wb_count", i), 128'(resWb), 128'(vecs[i].expWb));
            if (vecs[i].expWb != 0) begin
                checkOutput($sformatf("v%0d_wb_addr", i), {112'b0, resWbAddr}, {112'b0, vecs[i].expWbAddr});
                checkOutput($sformatf("v%0d_wb_data", i), resWbData, vecs[i].expWbData);
            end
            checkOutput($sformatf("v%0d_fill_count", i), 128'(resFill), 128'(vecs[i].expFill));
            if (vecs[i].expFill != 0)
                checkOutput($sformatf("v%0d_fill_addr", i), {112'b0, resFillAddr}, {112'b0, vecs[i].expFillAddr});
        end

`ifdef LINE_BUF_PERF_EN
        checkOutput("perf_hits",   {112'b0, hitCount},  128'd14);
        checkOutput("perf_misses", {112'b0, missCount}, 128'd4);
`endif

        // Reset in the middle of a fill must drop pmem_read without waiting for a clock.
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        bus.mem_address = 16'h1230;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_read && n < 10);
        checkOutput("fill_started", {127'b0, bus.pmem_read}, 128'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_fill_pmem_read", {127'b0, bus.pmem_read}, '0);
        checkOutput("rst_fill_mem_resp",  {127'b0, bus.mem_resp},  '0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000);
        checkOutput("post_rst_resp",       {127'b0, resGot}, 128'd1);
        checkOutput("post_rst_fill_count", 128'(resFill), 128'd1);
        checkOutput("post_rst_fill_addr",  {112'b0, resFillAddr}, 128'h1230);
        checkOutput("post_rst_lat",        128'(resLat), 128'd5);
        checkOutput("post_rst_rdata",      {112'b0, resRdata}, 128'hABC3);

        // A stray pmem_resp while idle must not start anything.
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        checkOutput("stray_mem_resp",   {127'b0, bus.mem_resp},   '0);
        checkOutput("stray_pmem_read",  {127'b0, bus.pmem_read},  '0);
        checkOutput("stray_pmem_write", {127'b0, bus.pmem_write}, '0);
        applyStimulus(1'b1, 1'b0, 16'h1232, 2'b00, 16'h0000);
        checkOutput("stray_hit_lat",   128'(resLat), 128'd2);
        checkOutput("stray_hit_rdata", {112'b0, resRdata}, 128'h1234);
        checkOutput("stray_hit_fills", 128'(resFill), '0);

`ifdef LINE_BUF_PERF_EN
        checkOutput("perf_hits_after_rst",   {112'b0, hitCount},  128'd2);
        checkOutput("perf_misses_after_rst", {112'b0, missCount}, 128'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
